// File: rtl/pwm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared definitions for the PWM duty-controller button front-end:
//   - state_e       : command FSM state encodings
//   - DIR_INC/DEC   : direction of the button currently being held
//   - cnt_width()   : register width needed for a counter that runs 0..n-1
// -----------------------------------------------------------------------------
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_e;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Width of a counter that must hold values 0..n-1 (never less than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a consecutive-cycle debounce counter.
// The stable level only follows the synchronised input after it has differed
// from the current stable level for DEBOUNCE_CYCLES consecutive cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing cycles required to accept (>=2)
// Ports:
//   clk    in  system clock
//   rst    in  synchronous, active-high reset
//   ena    in  low = hold every register
//   raw    in  asynchronous, bouncy button input
//   level  out debounced level
// -----------------------------------------------------------------------------
module btn_debounce
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic raw,
    output logic level
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = sync1_q;
        sync2_d  = sync2_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (ena) begin
            sync1_d = raw;
            sync2_d = sync1_q;
            if (sync2_q != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_d = sync2_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;

endmodule

// File: rtl/pwm_button_conditioner.sv
// -----------------------------------------------------------------------------
// pwm_button_conditioner
// Front-end for the PWM duty controller. Debounces the duty-up/duty-down
// buttons and turns debounced presses into one-cycle inc/dec commands.
// Simultaneous presses lock out all commands until both buttons are released.
//
// Build option: define AUTO_REPEAT_EN to build the repeat timer and ST_REPEAT
// so a held button keeps issuing commands; otherwise one command per press.
//
// Parameters:
//   DEBOUNCE_CYCLES      debounce acceptance length (>=2)
//   REPEAT_DELAY_CYCLES  first-pulse to first-repeat interval (AUTO_REPEAT_EN)
//   REPEAT_RATE_CYCLES   interval between repeats (AUTO_REPEAT_EN)
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ena          low = freeze all state, pulses forced low
//   btn_inc_raw  raw duty-up button
//   btn_dec_raw  raw duty-down button
//   inc_pulse    one-cycle duty-up command (registered)
//   dec_pulse    one-cycle duty-down command (registered)
//   inc_level    debounced duty-up level
//   dec_level    debounced duty-down level
//   lock         high while both buttons lock out commands
// -----------------------------------------------------------------------------
module pwm_button_conditioner
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = 50000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 8000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_level,
    output logic dec_level,
    output logic lock
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_param_check
        $error("pwm_button_conditioner: invalid timing parameters");
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .raw   (btn_inc_raw),
        .level (inc_level)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .raw   (btn_dec_raw),
        .level (dec_level)
    );

    state_e state_q, state_d;
    logic   dir_q, dir_d;
    logic   inc_pulse_q, inc_pulse_d;
    logic   dec_pulse_q, dec_pulse_d;
    logic   held_lvl, other_lvl;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned   TIMER_MAX  = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int unsigned   TW         = cnt_width(TIMER_MAX);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
`endif

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        inc_pulse_d = 1'b0;
        dec_pulse_d = 1'b0;
        held_lvl    = (dir_q == DIR_INC) ? inc_level : dec_level;
        other_lvl   = (dir_q == DIR_INC) ? dec_level : inc_level;
`ifdef AUTO_REPEAT_EN
        timer_d     = timer_q;
`endif
        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (inc_level && dec_level) begin
                        state_d = ST_LOCK;
                    end else if (inc_level || dec_level) begin
                        dir_d       = inc_level ? DIR_INC : DIR_DEC;
                        inc_pulse_d = inc_level;
                        dec_pulse_d = dec_level;
                        state_d     = ST_HOLD;
`ifdef AUTO_REPEAT_EN
                        timer_d     = '0;
`endif
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    // Lock is tested before release so a same-cycle release
                    // and other-press lands in ST_LOCK.
                    if (other_lvl) begin
                        state_d = ST_LOCK;
                    end else if (!held_lvl) begin
                        state_d = ST_IDLE;
                    end
`ifdef AUTO_REPEAT_EN
                    else if ((state_q == ST_HOLD   && timer_q == DELAY_LAST) ||
                             (state_q == ST_REPEAT && timer_q == RATE_LAST)) begin
                        inc_pulse_d = (dir_q == DIR_INC);
                        dec_pulse_d = (dir_q == DIR_DEC);
                        timer_d     = '0;
                        state_d     = ST_REPEAT;
                    end else if (timer_q != '1) begin
                        timer_d = timer_q + 1'b1;
                    end
`endif
                end
                ST_LOCK: begin
                    if (!inc_level && !dec_level) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_DEC;
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            inc_pulse_q <= inc_pulse_d;
            dec_pulse_q <= dec_pulse_d;
`ifdef AUTO_REPEAT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    // Pulse flops clear whenever ena is low; the gate also blanks a pulse
    // registered on the edge just before ena fell.
    assign inc_pulse = inc_pulse_q & ena;
    assign dec_pulse = dec_pulse_q & ena;
    assign lock      = (state_q == ST_LOCK);

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pwm_button_conditioner
// Directed bench for pwm_button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=5. A per-cycle vector table
// covers reset and clean inc/dec presses; hand-written sequences cover
// bounce, glitch length, auto-repeat, lockout, reset and enable cases.
// Expected pulse times are relative to the edge that first samples a raw step.
// -----------------------------------------------------------------------------
module tb_pwm_button_conditioner;

    logic clk = 1'b0;
    logic rst, ena, btn_inc_raw, btn_dec_raw;
    logic inc_pulse, dec_pulse, inc_level, dec_level, lock;

    always #5 clk = ~clk;

    pwm_button_conditioner #(
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (10),
        .REPEAT_RATE_CYCLES  (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .btn_inc_raw (btn_inc_raw),
        .btn_dec_raw (btn_dec_raw),
        .inc_pulse   (inc_pulse),
        .dec_pulse   (dec_pulse),
        .inc_level   (inc_level),
        .dec_level   (dec_level),
        .lock        (lock)
    );

    typedef struct packed {
        logic       rst;
        logic       inc;
        logic       dec;
        logic [4:0] exp;   // {inc_pulse, dec_pulse, inc_level, dec_level, lock}
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_n   = 0;
    int   both_hi = 0;
    int   inc_q[$];
    int   dec_q[$];
    int   t0, t1, t3, tr;
    int   exp_dec_offs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Apply inputs, take one rising edge, then sample just after it.
    task automatic step(input logic r, input logic e, input logic i, input logic d);
        rst         = r;
        ena         = e;
        btn_inc_raw = i;
        btn_dec_raw = d;
        @(posedge clk);
        cyc_n++;
        #1;
        if (inc_pulse && dec_pulse) both_hi++;
        if (inc_pulse) inc_q.push_back(cyc_n);
        if (dec_pulse) dec_q.push_back(cyc_n);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clr();
        inc_q.delete();
        dec_q.delete();
    endtask

    function automatic void add(input logic r, input logic i, input logic d, input logic [4:0] e);
        vec_t v;
        v.rst = r;
        v.inc = i;
        v.dec = d;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check_one(input string name, input int q[$], input int base, input int off);
        check({name, " count"}, q.size(), 1);
        if (q.size() > 0) check({name, " time"}, q[0] - base, off);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; btn_inc_raw = 1'b0; btn_dec_raw = 1'b0;

        // ---------------- vector table: reset + clean inc/dec press ----------
        add(1, 0, 0, 5'b00000);
        add(1, 0, 0, 5'b00000);
        add(0, 1, 0, 5'b00000);                            // k0: inc sampled
        repeat (4) add(0, 1, 0, 5'b00000);                 // k1..k4
        add(0, 1, 0, 5'b00100);                            // k5: level
        add(0, 1, 0, 5'b10100);                            // k6: pulse
        repeat (2) add(0, 1, 0, 5'b00100);                 // k7..k8
        repeat (5) add(0, 0, 0, 5'b00100);                 // k9..k13 release
        repeat (2) add(0, 0, 0, 5'b00000);                 // k14..k15
        repeat (5) add(0, 0, 1, 5'b00000);                 // k16..k20 dec
        add(0, 0, 1, 5'b00010);                            // k21
        add(0, 0, 1, 5'b01010);                            // k22
        add(0, 0, 1, 5'b00010);                            // k23
        repeat (5) add(0, 0, 0, 5'b00010);                 // k24..k28
        repeat (2) add(0, 0, 0, 5'b00000);                 // k29..k30

        for (int i = 0; i < vecs.size(); i++) begin
            logic [4:0] got;
            step(vecs[i].rst, 1'b1, vecs[i].inc, vecs[i].dec);
            got = {inc_pulse, dec_pulse, inc_level, dec_level, lock};
            n_tests++;
            if (got !== vecs[i].exp) begin
                n_fail++;
                $display("FAIL vec[%0d]: outputs=%b expected=%b", i, got, vecs[i].exp);
            end
        end
        idle(4);

        // ---------------- bounce: 1,1,0,0,1,1,0,0 then held -----------------
        clr();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, ((k / 2) % 2) == 0, 1'b0);
        t0 = cyc_n + 1;
        repeat (15) step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(12);
        check_one("bounce inc_pulse", inc_q, t0, 6);

        // ---------------- glitch lengths: 3 rejected, 4 accepted -------------
        clr();
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(12);
        check("glitch3 pulses", inc_q.size(), 0);
        clr();
        t0 = cyc_n + 1;
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(14);
        check_one("glitch4 inc_pulse", inc_q, t0, 6);

        // ---------------- dec held: auto-repeat or single pulse --------------
`ifdef AUTO_REPEAT_EN
        exp_dec_offs = '{6, 16, 21, 26, 31, 36, 41, 46};
`else
        exp_dec_offs = '{6};
`endif
        clr();
        t0 = cyc_n + 1;
        repeat (43) step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(12);
        check("hold dec count", dec_q.size(), exp_dec_offs.size());
        check("hold inc count", inc_q.size(), 0);
        for (int j = 0; j < exp_dec_offs.size(); j++) begin
            if (j < dec_q.size()) check($sformatf("hold dec[%0d] time", j), dec_q[j] - t0, exp_dec_offs[j]);
        end

        // ---------------- simultaneous press -> lock ------------------------
        clr();
        t0 = cyc_n + 1;
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b1);           // through t0+5
        check("simul levels", {30'd0, inc_level, dec_level}, 3);
        check("simul lock t0+5", lock, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);                      // t0+6
        check("simul lock t0+6", lock, 1);
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b1);
        t1 = cyc_n + 1;
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);           // through t1+5
        check("simul lock rel+5", lock, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);                      // t1+6
        check("simul lock rel+6", lock, 0);
        check("simul pulses", inc_q.size() + dec_q.size(), 0);
        idle(2);
        clr();
        t0 = cyc_n + 1;
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(12);
        check_one("post-lock inc_pulse", inc_q, t0, 6);

        // ---------------- dec pressed while inc held ------------------------
        clr();
        t0 = cyc_n + 1;
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0);
        t1 = cyc_n + 1;
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b1);           // through t1+5
        check("other lock t1+5", lock, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);                      // t1+6
        check("other lock t1+6", lock, 1);
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1, 1'b1, 1'b0);          // dec released only
        check("other lock dec released", lock, 1);
        t3 = cyc_n + 1;
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("other lock inc rel+5", lock, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("other lock inc rel+6", lock, 0);
        check("other dec pulses", dec_q.size(), 0);
        check_one("other inc_pulse", inc_q, t0, 6);
        idle(4);

        // ---------------- reset while inc held ------------------------------
        clr();
        repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("reset outputs", {27'd0, inc_pulse, dec_pulse, inc_level, dec_level, lock}, 0);
        clr();
        tr = cyc_n + 1;
        repeat (12) step(1'b0, 1'b1, 1'b1, 1'b0);
        check_one("post-reset inc_pulse", inc_q, tr, 6);
        idle(12);

        // ---------------- ena low freezes timing ----------------------------
        clr();
        t0 = cyc_n + 1;
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(12);
        check_one("ena-freeze inc_pulse", inc_q, t0, 9);

        check("inc/dec pulse overlap", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
